// File: rtl/half2_sched_pkg.sv
// Shared types and widths for the half2 front-end scheduler.
package half2_sched_pkg;

  localparam int unsigned IN_W   = 16;
  localparam int unsigned OUT_W  = 17;
  localparam int unsigned UCNT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_e;

endpackage

// File: rtl/half2_sched_tag_delay.sv
// Fixed-depth delay line of {phase, valid} tags that travel alongside an
// interleaved filter pipeline. Stage 0 is the newest tag and the top stage
// is the one leaving the pipe.
module tag_delay #(
  parameter int unsigned DEPTH = 6
) (
  input  logic clk_i,
  input  logic clr_i,
  input  logic phase_i,
  input  logic valid_i,
  output logic phase_o,
  output logic valid_o
);

  logic [2*DEPTH-1:0] pipe_q;
  logic [2*DEPTH-1:0] pipe_d;

  generate
    if (DEPTH == 1) begin : g_one
      // Single stage: the new tag replaces the only entry.
      always_comb pipe_d = {phase_i, valid_i};
    end else begin : g_multi
      // Shift every tag one stage towards the output and insert the new one.
      always_comb pipe_d = {pipe_q[2*DEPTH-3:0], phase_i, valid_i};
    end
  endgenerate

  // Tag register with synchronous clear.
  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign phase_o = pipe_q[2*DEPTH-1];
  assign valid_o = pipe_q[2*DEPTH-2];

endmodule

// File: rtl/half2_sched.sv
// Scheduler / demultiplexer around the two-channel interleaved half-band
// filter half2: frames two input streams onto a/b/ab, tracks the filter
// latency with a tag pipe, and returns each result on its own channel.
module half2_sched
  import half2_sched_pkg::*;
#(
  parameter int unsigned LAT        = 6,
  parameter int unsigned PRIME_LEN  = 16,
  parameter bit          ZERO_STUFF = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [IN_W-1:0]   in_a,
  input  logic              in_a_valid,
  input  logic [IN_W-1:0]   in_b,
  input  logic              in_b_valid,
  output logic              f_ab,
  output logic [IN_W-1:0]   f_a,
  output logic [IN_W-1:0]   f_b,
  input  logic [OUT_W-1:0]  f_d,
  output logic [OUT_W-1:0]  out_a,
  output logic              out_a_strobe,
  output logic [OUT_W-1:0]  out_b,
  output logic              out_b_strobe,
  output logic              running,
  output logic              overrun,
  output logic [UCNT_W-1:0] underrun_cnt
);

  localparam logic [7:0] PRIME_LD = 8'(PRIME_LEN);
  localparam logic [7:0] DRAIN_LD = 8'(LAT + (LAT % 2));

  state_e            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              ab_q, ab_d;
  logic              frame_start;

  logic [IN_W-1:0]   hold_a_q, hold_a_d, hold_b_q, hold_b_d;
  logic              got_a_q, got_a_d, got_b_q, got_b_d;
  logic [IN_W-1:0]   fa_q, fa_d, fb_q, fb_d;
  logic              ovr_q, ovr_d;
  logic [UCNT_W-1:0] ucnt_q, ucnt_d;
  logic [OUT_W-1:0]  out_a_q, out_b_q;

  logic [IN_W-1:0]   samp_a, samp_b;
  logic              have_a, have_b;
  logic              to_run, to_live, under;
  logic              tag_ph, tag_v;

  // Sequencer: phase toggle, prime/drain counter and state transitions.
  // Every non-IDLE exit happens on a cycle with ab_q=1, i.e. a frame boundary.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ab_d        = 1'b0;
    frame_start = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enable) begin
          state_d     = PRIME;
          cnt_d       = PRIME_LD;
          frame_start = 1'b1;
        end
      end
      PRIME: begin
        ab_d  = ~ab_q;
        cnt_d = cnt_q - 8'd1;
        if (ab_q) begin
          frame_start = 1'b1;
          if (!enable) begin
            state_d = DRAIN;
            cnt_d   = DRAIN_LD;
          end else if (cnt_q == 8'd1) begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        ab_d = ~ab_q;
        if (ab_q) begin
          frame_start = 1'b1;
          if (!enable) begin
            state_d = DRAIN;
            cnt_d   = DRAIN_LD;
          end
        end
      end
      DRAIN: begin
        ab_d  = ~ab_q;
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) begin
          frame_start = 1'b1;
          if (enable) begin
            state_d = PRIME;
            cnt_d   = PRIME_LD;
          end else begin
            state_d = IDLE;
          end
        end
      end
    endcase
  end

  // Input capture, per-frame presentation, overrun and underrun accounting.
  // A valid arriving on the last cycle of a frame is bypassed straight into
  // the presentation register since the holding register updates on the same edge.
  always_comb begin
    samp_a   = in_a_valid ? in_a : hold_a_q;
    samp_b   = in_b_valid ? in_b : hold_b_q;
    have_a   = got_a_q | in_a_valid;
    have_b   = got_b_q | in_b_valid;
    to_run   = (state_d == RUN);
    to_live  = (state_d == RUN) || (state_d == PRIME);
    hold_a_d = samp_a;
    hold_b_d = samp_b;
    got_a_d  = have_a;
    got_b_d  = have_b;
    fa_d     = fa_q;
    fb_d     = fb_q;
    under    = 1'b0;
    if (state_q == IDLE) begin
      got_a_d = 1'b0;
      got_b_d = 1'b0;
    end
    if (frame_start) begin
      got_a_d = 1'b0;
      got_b_d = 1'b0;
      if (to_live) begin
        fa_d  = (to_run && !have_a && ZERO_STUFF) ? '0 : samp_a;
        fb_d  = (to_run && !have_b && ZERO_STUFF) ? '0 : samp_b;
        under = to_run && !(have_a && have_b);
      end else begin
        fa_d = '0;
        fb_d = '0;
      end
    end
    ovr_d  = ovr_q | ((state_q != IDLE) &&
                      ((in_a_valid && got_a_q) || (in_b_valid && got_b_q)));
    ucnt_d = (under && (ucnt_q != '1)) ? ucnt_q + UCNT_W'(1) : ucnt_q;
  end

  // State, datapath and result-hold registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      ab_q     <= 1'b0;
      hold_a_q <= '0;
      hold_b_q <= '0;
      got_a_q  <= 1'b0;
      got_b_q  <= 1'b0;
      fa_q     <= '0;
      fb_q     <= '0;
      ovr_q    <= 1'b0;
      ucnt_q   <= '0;
      out_a_q  <= '0;
      out_b_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ab_q     <= ab_d;
      hold_a_q <= hold_a_d;
      hold_b_q <= hold_b_d;
      got_a_q  <= got_a_d;
      got_b_q  <= got_b_d;
      fa_q     <= fa_d;
      fb_q     <= fb_d;
      ovr_q    <= ovr_d;
      ucnt_q   <= ucnt_d;
      if (out_a_strobe) out_a_q <= f_d;
      if (out_b_strobe) out_b_q <= f_d;
    end
  end

  tag_delay #(
    .DEPTH (LAT)
  ) u_tags (
    .clk_i   (clk),
    .clr_i   (rst),
    .phase_i (ab_q),
    .valid_i (state_q == RUN),
    .phase_o (tag_ph),
    .valid_o (tag_v)
  );

  assign out_a_strobe = tag_v & ~tag_ph & ~rst;
  assign out_b_strobe = tag_v &  tag_ph & ~rst;
  assign out_a        = out_a_strobe ? f_d : out_a_q;
  assign out_b        = out_b_strobe ? f_d : out_b_q;

  assign f_ab         = ab_q;
  assign f_a          = fa_q;
  assign f_b          = fb_q;
  assign running      = (state_q != IDLE);
  assign overrun      = ovr_q;
  assign underrun_cnt = ucnt_q;

endmodule

// File: tb/tb_half2_sched.sv
// Directed bench for half2_sched. half2 is stood in for by a pure LAT-cycle
// delay of the selected a/b sample, so each result equals the presented sample.
module tb_half2_sched;

  localparam int unsigned LAT       = 6;
  localparam int unsigned PRIME_LEN = 16;

  logic        clk = 1'b0;
  logic        rst, enable;
  logic [15:0] in_a, in_b;
  logic        in_a_valid, in_b_valid;
  logic        f_ab;
  logic [15:0] f_a, f_b;
  logic [16:0] f_d;
  logic [16:0] out_a, out_b;
  logic        out_a_strobe, out_b_strobe;
  logic        running, overrun;
  logic [7:0]  underrun_cnt;

  logic [17*LAT-1:0] mdl;
  logic [16:0]       exp_oa, exp_ob;
  logic              stb;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  half2_sched #(
    .LAT        (LAT),
    .PRIME_LEN  (PRIME_LEN),
    .ZERO_STUFF (1'b1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .in_a         (in_a),
    .in_a_valid   (in_a_valid),
    .in_b         (in_b),
    .in_b_valid   (in_b_valid),
    .f_ab         (f_ab),
    .f_a          (f_a),
    .f_b          (f_b),
    .f_d          (f_d),
    .out_a        (out_a),
    .out_a_strobe (out_a_strobe),
    .out_b        (out_b),
    .out_b_strobe (out_b_strobe),
    .running      (running),
    .overrun      (overrun),
    .underrun_cnt (underrun_cnt)
  );

  // Stand-in filter: LAT-cycle delay of the sample selected by ab.
  always @(posedge clk) begin
    if (rst) mdl <= '0;
    else     mdl <= {mdl[17*(LAT-1)-1:0], (f_ab ? {f_b[15], f_b} : {f_a[15], f_a})};
  end
  assign f_d = mdl[17*LAT-1 -: 17];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Frame-indexed stimulus for the main run; frame k starts T0+2k.
  function automatic logic [15:0] smp_a(input int k);
    if (k == 12) return 16'd1024;
    if (k >= 17) return 16'd500;
    return '0;
  endfunction

  function automatic logic va(input int k);
    return (k < 28) && !(k >= 20 && k <= 22);
  endfunction

  function automatic logic [15:0] smp_b(input int k);
    if (k == 24) return 16'd100;
    return 16'(-20000 + 1500 * k);
  endfunction

  // Expected f_a / f_b in frame k: previous frame's sample while PRIME/RUN
  // (frames 1..28), zero-stuffed on underrun, zero in DRAIN and IDLE.
  function automatic logic [15:0] pa(input int k);
    if (k < 1 || k > 28) return '0;
    return va(k - 1) ? smp_a(k - 1) : '0;
  endfunction

  function automatic logic [15:0] pb(input int k);
    if (k < 1 || k > 28) return '0;
    return (k == 25) ? 16'd200 : smp_b(k - 1);
  endfunction

  function automatic logic [16:0] sx(input logic [15:0] v);
    return {v[15], v};
  endfunction

  function automatic int uexp(input int k);
    if (k < 21) return 0;
    if (k <= 23) return k - 20;
    return 3;
  endfunction

  initial begin
    rst = 1'b1; enable = 1'b0;
    in_a = '0; in_b = '0; in_a_valid = 1'b0; in_b_valid = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();

    check("rst_f_ab",    32'(f_ab),         32'd0);
    check("rst_f_a",     32'(f_a),          32'd0);
    check("rst_f_b",     32'(f_b),          32'd0);
    check("rst_out_a",   32'(out_a),        32'd0);
    check("rst_out_b",   32'(out_b),        32'd0);
    check("rst_stb",     32'({out_a_strobe, out_b_strobe}), 32'd0);
    check("rst_running", 32'(running),      32'd0);
    check("rst_ovr",     32'(overrun),      32'd0);
    check("rst_ucnt",    32'(underrun_cnt), 32'd0);

    // Main run: PRIME frames 0-7, RUN 8-28, DRAIN 29-31, IDLE 32+.
    enable = 1'b1;
    tick();
    exp_oa = '0;
    exp_ob = '0;
    for (int k = 0; k < 34; k++) begin
      enable     = (k < 28);
      in_a       = smp_a(k);
      in_a_valid = va(k);
      in_b       = smp_b(k);
      in_b_valid = (k < 28);
      stb        = (k >= 11) && (k <= 31);
      if (stb) exp_oa = sx(pa(k - 3));
      check($sformatf("f_ab0 k%0d", k),   32'(f_ab),         32'd0);
      check($sformatf("run k%0d", k),     32'(running),      32'(k <= 31));
      check($sformatf("f_a k%0d", k),     32'(f_a),          32'(pa(k)));
      check($sformatf("f_b k%0d", k),     32'(f_b),          32'(pb(k)));
      check($sformatf("stb_a k%0d", k),   32'(out_a_strobe), 32'(stb));
      check($sformatf("stb_b0 k%0d", k),  32'(out_b_strobe), 32'd0);
      check($sformatf("out_a k%0d", k),   32'(out_a),        32'(exp_oa));
      check($sformatf("out_b0 k%0d", k),  32'(out_b),        32'(exp_ob));
      check($sformatf("ucnt k%0d", k),    32'(underrun_cnt), 32'(uexp(k)));
      check($sformatf("ovr k%0d", k),     32'(overrun),      32'(k >= 25));
      tick();
      in_a_valid = 1'b0;
      in_b_valid = (k == 24);
      in_b       = (k == 24) ? 16'd200 : '0;
      if (stb) exp_ob = sx(pb(k - 3));
      check($sformatf("f_ab1 k%0d", k),   32'(f_ab),         32'(k <= 31));
      check($sformatf("f_a1 k%0d", k),    32'(f_a),          32'(pa(k)));
      check($sformatf("f_b1 k%0d", k),    32'(f_b),          32'(pb(k)));
      check($sformatf("stb_a1 k%0d", k),  32'(out_a_strobe), 32'd0);
      check($sformatf("stb_b k%0d", k),   32'(out_b_strobe), 32'(stb));
      check($sformatf("out_a1 k%0d", k),  32'(out_a),        32'(exp_oa));
      check($sformatf("out_b k%0d", k),   32'(out_b),        32'(exp_ob));
      tick();
    end
    in_b_valid = 1'b0;

    // Enable dropped in RUN, re-asserted during DRAIN: straight back to PRIME.
    enable = 1'b1;
    tick();
    repeat (24) tick();
    enable = 1'b0;
    tick();
    check("wait_boundary_run", 32'(running), 32'd1);
    check("wait_boundary_ab",  32'(f_ab),    32'd1);
    tick();
    enable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check($sformatf("drain_run i%0d", i),  32'(running),      32'd1);
      check($sformatf("drain_ab i%0d", i),   32'(f_ab),         32'(i % 2));
      check($sformatf("drain_fa i%0d", i),   32'(f_a),          32'd0);
      check($sformatf("drain_fb i%0d", i),   32'(f_b),          32'd0);
      check($sformatf("drain_sa i%0d", i),   32'(out_a_strobe), 32'(i % 2 == 0));
      check($sformatf("drain_sb i%0d", i),   32'(out_b_strobe), 32'(i % 2 == 1));
      tick();
    end
    check("reprime_run", 32'(running),      32'd1);
    check("reprime_ab0", 32'(f_ab),         32'd0);
    check("reprime_sa",  32'(out_a_strobe), 32'd0);
    tick();
    check("reprime_ab1", 32'(f_ab),         32'd1);
    check("reprime_sb",  32'(out_b_strobe), 32'd0);

    // Long RUN without input: underrun counter saturates; then feed data
    // so results are in flight when reset hits.
    repeat (15) tick();
    repeat (600) tick();
    check("ucnt_sat",   32'(underrun_cnt), 32'd255);
    check("ovr_sticky", 32'(overrun),      32'd1);
    in_a = 16'h1234; in_b = 16'h4321;
    in_a_valid = 1'b1; in_b_valid = 1'b1;
    repeat (20) tick();
    check("pre_rst_out_a", 32'(out_a),   32'h01234);
    check("pre_rst_out_b", 32'(out_b),   32'h04321);
    check("pre_rst_run",   32'(running), 32'd1);

    rst = 1'b1; enable = 1'b0;
    in_a_valid = 1'b0; in_b_valid = 1'b0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check($sformatf("post_rst_stb i%0d", i),  32'({out_a_strobe, out_b_strobe}), 32'd0);
      check($sformatf("post_rst_out i%0d", i),  32'({out_a, out_b}),               32'd0);
      check($sformatf("post_rst_f i%0d", i),    32'({f_ab, f_a, f_b}),             32'd0);
      check($sformatf("post_rst_run i%0d", i),  32'(running),                      32'd0);
      check($sformatf("post_rst_ovr i%0d", i),  32'(overrun),                      32'd0);
      check($sformatf("post_rst_ucnt i%0d", i), 32'(underrun_cnt),                 32'd0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
